// File: rtl/dm_load_aligner_if.sv
// MEM/WB load-return bundle between the pipeline, data SRAM read port
// and the writeback stage.
interface dm_load_aligner_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            stall;
    logic            flush;
    logic [6:0]      M_op;
    logic [2:0]      M_funct3;
    logic [XLEN-1:0] M_alu_out;
    logic [RD_W-1:0] M_rd;
    logic [XLEN-1:0] dm_data_out;
    logic            W_ld_valid;
    logic [RD_W-1:0] W_rd;
    logic [XLEN-1:0] W_ld_data;
    logic            W_ld_misalign;

    modport master (
        output stall, flush,
        output M_op, M_funct3, M_alu_out, M_rd,
        output dm_data_out,
        input  W_ld_valid, W_rd, W_ld_data, W_ld_misalign
    );

    modport slave (
        input  stall, flush,
        input  M_op, M_funct3, M_alu_out, M_rd,
        input  dm_data_out,
        output W_ld_valid, W_rd, W_ld_data, W_ld_misalign
    );
endinterface

// File: rtl/dm_load_aligner.sv
// Load-return aligner: tracks a load alongside the synchronous SRAM read,
// then lane-selects and extends the returned word for writeback.
module dm_load_aligner #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input logic              clk,
    input logic              rst_n,
    dm_load_aligner_if.slave bus
);
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic            pend_valid;
    logic [2:0]      pend_f3;
    logic [1:0]      pend_off;
    logic [RD_W-1:0] pend_rd;
    logic [XLEN-1:0] hold_data;
    logic            captured;

    logic            m_is_load;
    assign m_is_load = (bus.M_op == OP_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_f3    <= '0;
            pend_off   <= '0;
            pend_rd    <= '0;
            hold_data  <= '0;
            captured   <= 1'b0;
        end else if (!bus.stall) begin
            pend_valid <= m_is_load & ~bus.flush;
            pend_f3    <= bus.M_funct3;
            pend_off   <= bus.M_alu_out[1:0];
            pend_rd    <= bus.M_rd;
            captured   <= 1'b0;
        end else if (bus.flush) begin
            pend_valid <= 1'b0;
            captured   <= 1'b0;
        end else if (pend_valid && !captured) begin
            // SRAM output is only good for one cycle; latch it on the first stall
            hold_data <= bus.dm_data_out;
            captured  <= 1'b1;
        end
    end

    logic [XLEN-1:0] src;
    logic [XLEN-1:0] lane;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            sext;
    logic            is_b;
    logic            is_h;
    logic            is_w;
    logic [XLEN-1:0] data;

    assign src    = captured ? hold_data : bus.dm_data_out;
    assign lane   = src >> {pend_off, 3'b000};
    assign byte_v = lane[7:0];
    assign half_v = pend_off[1] ? src[31:16] : src[15:0];
    assign sext   = ~pend_f3[2];
    assign is_b   = (pend_f3[1:0] == 2'b00);
    assign is_h   = (pend_f3[1:0] == 2'b01);
    assign is_w   = (pend_f3 == 3'b010);

    always_comb begin
        data = '0;
        unique case (1'b1)
            is_b:    data = {{(XLEN-8){sext & byte_v[7]}}, byte_v};
            is_h:    data = {{(XLEN-16){sext & half_v[15]}}, half_v};
            is_w:    data = src;
            default: data = '0;
        endcase
    end

    assign bus.W_ld_valid    = pend_valid;
    assign bus.W_rd          = pend_rd;
    assign bus.W_ld_data     = pend_valid ? data : '0;
    assign bus.W_ld_misalign = pend_valid &
                               ((is_h & pend_off[0]) |
                                (is_w & (pend_off != 2'b00)));
endmodule

// File: doc/dm_load_aligner.md
Name: dm_load_aligner

Overview:
- Sits downstream of the MEM-stage store aligner/address generator, on the read side of the word-addressed data SRAM.
- Registers each load's metadata in lockstep with the synchronous SRAM read.
- One cycle later it selects the byte or halfword lane from the SRAM read word and sign- or zero-extends it for writeback.
- Holds the read result stable across pipeline stalls, even while the SRAM address moves on.

Parameters:
- XLEN, 32, data width of SRAM word and result.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  1 = MEM/WB pipeline register holds (no advance).
- flush  input  1  1 = squash the instruction entering WB this edge.
- M_op  input  7  MEM-stage opcode; a load is 7'b0000011.
- M_funct3  input  3  MEM-stage funct3.
- M_alu_out  input  XLEN  MEM-stage effective byte address; only bits [1:0] are used.
- M_rd  input  RD_W  MEM-stage destination register.
- dm_data_out  input  XLEN  SRAM read word; valid the cycle after the address is presented.
- W_ld_valid  output  1  WB stage holds a live load.
- W_rd  output  RD_W  destination register of that load.
- W_ld_data  output  XLEN  aligned, extended load result.
- W_ld_misalign  output  1  load address violates natural alignment.

Behaviour:
- Reset (async, rst_n=0): all registers clear.
  - Outputs: W_ld_valid=0, W_rd=0, W_ld_data=0, W_ld_misalign=0.
  - The hold register is cleared and the captured flag is 0.
- Registered state:
  - pend_valid, pend_f3[2:0], pend_off[1:0], pend_rd.
  - hold_data[XLEN-1:0] and captured (1 bit).
- Advance edge (stall=0):
  - pend_valid <= (M_op==LOAD) & ~flush.
  - pend_f3, pend_off, pend_rd <= M_funct3, M_alu_out[1:0], M_rd.
  - captured <= 0.
- Stall edge (stall=1):
  - pend_* hold.
  - If pend_valid & ~captured: hold_data <= dm_data_out and captured <= 1.
  - Otherwise hold_data and captured hold.
- flush has priority over stall when both are 1: pend_valid <= 0 and captured <= 0.
- Source word: src = captured ? hold_data : dm_data_out.
- Load latency: result is combinational from src, valid in the cycle after the load's advance edge, and stays stable for every stalled cycle after that.
- Lane select is little-endian: byte k = src[8k+7:8k], where k = pend_off.
- Extraction by pend_f3:
  - 000 LB: sign-extend byte at pend_off.
  - 100 LBU: zero-extend byte at pend_off.
  - 001 LH: sign-extend src[31:16] if pend_off[1], else src[15:0].
  - 101 LHU: as LH, zero-extended.
  - 010 LW: src unchanged.
  - Any other funct3: W_ld_data=0.
- W_ld_misalign = pend_valid & ((LH/LHU & pend_off[0]) | (LW & pend_off!=0)).
  - Data is still produced using the lane rules above.
  - pend_off[0] is ignored for halfwords; pend_off is ignored for LW.
- When pend_valid=0: W_ld_valid=0, W_ld_data=0, W_ld_misalign=0. W_rd still shows pend_rd.
- Stores and ALU ops passing through give pend_valid=0; dm_data_out is ignored.
- Back-to-back loads:
  - Each advance edge replaces the pending load.
  - There is no bubble requirement; throughput is 1 load/cycle when stall=0.
- Reset asserted mid-stall discards the captured data immediately (async). The first result after deassertion comes only from a new load.

Test Plan:
- Reset: hold rst_n=0 with a load pending -> all outputs 0 asynchronously; after release with no load, W_ld_valid=0.
- Byte lanes: dm_data_out=32'h80FF7F01, LB at off 0,1,2,3 -> W_ld_data = 00000001, 0000007F, FFFFFFFF, FFFFFF80; LBU off 3 -> 00000080.
- Halfwords: dm_data_out=32'h8001_7FFE; LH off 2 -> FFFF8001; LHU off 0 -> 00007FFE; LH off 1 -> W_ld_misalign=1 with data 00007FFE.
- Stall hold: LW with dm_data_out=32'hDEADBEEF, then stall=1 for 3 cycles while dm_data_out changes to 32'h12345678 -> W_ld_data stays DEADBEEF for all 4 cycles; W_ld_valid=1 throughout.
- Flush: load with flush=1 (stall=0) at the advance edge -> W_ld_valid=0 next cycle; flush=1 and stall=1 together -> W_ld_valid=0 and captured cleared.
- Back-to-back: LW rd=5 then LBU rd=6 off 2 on consecutive cycles, words 32'h11223344 then 32'hAABBCCDD -> W_rd=5/data 11223344, then W_rd=6/data 000000BB.
